fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with 1-entry skid, redirect flush and drain.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirects go to TRAP_PC and pulse misalign.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_lock,
  input  logic        control_change,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        misalign
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        skid_v_q, skid_v_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pco_q, pco_d;
  logic [31:0] redir_pc;
  logic        resp, issue_rdata, issue_skid;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        mis_q, mis_d;
  assign redir_pc = |redirect_pc[1:0] ? TRAP_PC : redirect_pc;
  assign misalign = mis_q;
`else
  assign redir_pc = redirect_pc & ~32'h3;
  assign misalign = 1'b0;
`endif
  assign imem_addr   = pc_q;
  assign imem_req    = !rst && state_q == S_REQ && !pc_lock;
  assign resp        = state_q == S_WAIT && imem_rvalid;
  assign issue_rdata = !control_change && resp && !pc_lock;
  assign issue_skid  = !control_change && skid_v_q && !pc_lock;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      skid_v_q    <= 1'b0;
      skid_inst_q <= NOP;
      skid_pc_q   <= '0;
      inst_q      <= NOP;
      pco_q       <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      skid_v_q    <= skid_v_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
      inst_q      <= inst_d;
      pco_q       <= pco_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q       <= mis_d;
`endif
    end
  end
  // A grant taken alongside a redirect fetches a stale address, so its response is drained.
  always_comb begin
    state_d = state_q;
    if (state_q == S_REQ)
      state_d = imem_req && imem_gnt ? (control_change ? S_DRAIN : S_WAIT) : S_REQ;
    else if (state_q == S_WAIT)
      state_d = imem_rvalid ? S_REQ : (control_change ? S_DRAIN : S_WAIT);
    else
      state_d = imem_rvalid ? S_REQ : S_DRAIN;
  end
  always_comb begin
    pc_d        = control_change ? redir_pc : resp ? pc_q + 32'd4 : pc_q;
    skid_v_d    = control_change ? 1'b0 : (resp && pc_lock) ? 1'b1 : issue_skid ? 1'b0 : skid_v_q;
    skid_inst_d = (!control_change && resp && pc_lock) ? imem_rdata : skid_inst_q;
    skid_pc_d   = (!control_change && resp && pc_lock) ? pc_q : skid_pc_q;
    inst_d      = issue_rdata ? imem_rdata : issue_skid ? skid_inst_q : NOP;
    pco_d       = issue_rdata ? pc_q : issue_skid ? skid_pc_q : 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
    mis_d       = control_change && |redirect_pc[1:0];
`endif
  end
  assign inst_out = inst_q;
  assign pc_out   = pco_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus hand sequences for wrap and mid-transaction reset.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] A = 32'h0050_0093, B = 32'h0010_0113, C = 32'h0020_8193;
  localparam logic [31:0] D = 32'hDEAD_BEEF, E = 32'hCAFE_F00D, F = 32'h0000_0073;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [31:0] MIS_ADDR = 32'h0000_0100;
  localparam logic        MIS_EXP  = 1'b1;
`else
  localparam logic [31:0] MIS_ADDR = 32'h0000_0040;
  localparam logic        MIS_EXP  = 1'b0;
`endif
  logic        clk = 0, rst = 1, pc_lock = 0, control_change = 0, imem_gnt = 0, imem_rvalid = 0;
  logic [31:0] redirect_pc = 0, imem_rdata = 0;
  logic        imem_req, misalign;
  logic [31:0] imem_addr, pc_out, inst_out;
  int checks = 0, failures = 0;
  typedef struct {
    logic        lock, cc;
    logic [31:0] rpc;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        ereq;
    logic [31:0] eaddr, einst, epco;
    logic        emis;
  } vec_t;
  vec_t v[$];
  fetch_unit dut (
    .clk(clk), .rst(rst), .pc_lock(pc_lock), .control_change(control_change),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_out(pc_out), .inst_out(inst_out), .misalign(misalign)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic lock, logic cc, logic [31:0] rpc, logic gnt, logic rv,
                              logic [31:0] rdata, logic ereq, logic [31:0] eaddr,
                              logic [31:0] einst, logic [31:0] epco, logic emis);
    vec_t x;
    x.lock = lock; x.cc = cc; x.rpc = rpc; x.gnt = gnt; x.rv = rv; x.rdata = rdata;
    x.ereq = ereq; x.eaddr = eaddr; x.einst = einst; x.epco = epco; x.emis = emis;
    return x;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic step(input vec_t x, input string tag);
    @(negedge clk);
    pc_lock = x.lock; control_change = x.cc; redirect_pc = x.rpc;
    imem_gnt = x.gnt; imem_rvalid = x.rv; imem_rdata = x.rdata;
    #1;
    chk({tag, ".req"}, {31'b0, imem_req}, {31'b0, x.ereq});
    chk({tag, ".addr"}, imem_addr, x.eaddr);
    @(posedge clk);
    #1;
    chk({tag, ".inst"}, inst_out, x.einst);
    chk({tag, ".pco"}, pc_out, x.epco);
    chk({tag, ".mis"}, {31'b0, misalign}, {31'b0, x.emis});
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, ".req"}, {31'b0, imem_req}, 32'h0);
    chk({tag, ".addr"}, imem_addr, 32'h0);
    chk({tag, ".inst"}, inst_out, NOP);
    chk({tag, ".pco"}, pc_out, 32'h0);
    chk({tag, ".mis"}, {31'b0, misalign}, 32'h0);
  endtask
  initial begin
    //          lock cc rpc          gnt rv rdata  req addr          inst  pco           mis
    v.push_back(mk(0, 0, 0,            1, 0, 0,     1, 32'h0,         NOP,  32'h0,        0));
    v.push_back(mk(0, 0, 0,            0, 1, A,     0, 32'h0,         A,    32'h0,        0));
    v.push_back(mk(0, 0, 0,            1, 0, 0,     1, 32'h4,         NOP,  32'h0,        0));
    v.push_back(mk(0, 0, 0,            0, 1, A,     0, 32'h4,         A,    32'h4,        0));
    v.push_back(mk(0, 0, 0,            1, 0, 0,     1, 32'h8,         NOP,  32'h0,        0));
    v.push_back(mk(1, 0, 0,            0, 1, B,     0, 32'h8,         NOP,  32'h0,        0));
    v.push_back(mk(1, 0, 0,            1, 0, 0,     0, 32'hC,         NOP,  32'h0,        0));
    v.push_back(mk(0, 0, 0,            1, 0, 0,     1, 32'hC,         B,    32'h8,        0));
    v.push_back(mk(0, 0, 0,            0, 1, C,     0, 32'hC,         C,    32'hC,        0));
    v.push_back(mk(0, 0, 0,            1, 0, 0,     1, 32'h10,        NOP,  32'h0,        0));
    v.push_back(mk(0, 1, 32'h40,       0, 0, 0,     0, 32'h10,        NOP,  32'h0,        0));
    v.push_back(mk(0, 0, 0,            1, 0, 0,     0, 32'h40,        NOP,  32'h0,        0));
    v.push_back(mk(0, 0, 0,            0, 1, D,     0, 32'h40,        NOP,  32'h0,        0));
    v.push_back(mk(0, 0, 0,            1, 0, 0,     1, 32'h40,        NOP,  32'h0,        0));
    v.push_back(mk(1, 1, 32'h80,       0, 1, E,     0, 32'h40,        NOP,  32'h0,        0));
    v.push_back(mk(0, 0, 0,            0, 0, 0,     1, 32'h80,        NOP,  32'h0,        0));
    v.push_back(mk(0, 0, 0,            1, 0, 0,     1, 32'h80,        NOP,  32'h0,        0));
    v.push_back(mk(0, 0, 0,            0, 1, F,     0, 32'h80,        F,    32'h80,       0));
    v.push_back(mk(0, 1, 32'hC0,       1, 0, 0,     1, 32'h84,        NOP,  32'h0,        0));
    v.push_back(mk(0, 0, 0,            0, 1, D,     0, 32'hC0,        NOP,  32'h0,        0));
    v.push_back(mk(0, 1, 32'h42,       0, 0, 0,     1, 32'hC0,        NOP,  32'h0,        MIS_EXP));
    v.push_back(mk(1, 0, 0,            0, 0, 0,     0, MIS_ADDR,      NOP,  32'h0,        0));
    #12;
    chk_reset("rst_hold");
    @(negedge clk);
    rst = 0;
    foreach (v[i]) step(v[i], $sformatf("v%0d", i));
    @(negedge clk);
    pc_lock = 0; control_change = 0; imem_gnt = 0; imem_rvalid = 0; rst = 1;
    #1;
    chk_reset("rst_async");
    @(negedge clk);
    rst = 0;
    step(mk(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 1, 32'h0,         NOP, 32'h0,         0), "w0");
    step(mk(0, 0, 0,             1, 0, 0, 1, 32'hFFFF_FFFC, NOP, 32'h0,         0), "w1");
    step(mk(0, 0, 0,             0, 1, A, 0, 32'hFFFF_FFFC, A,   32'hFFFF_FFFC, 0), "w2");
    step(mk(0, 0, 0,             1, 0, 0, 1, 32'h0,         NOP, 32'h0,         0), "w3");
    step(mk(0, 0, 0,             0, 1, C, 0, 32'h0,         C,   32'h0,         0), "w4");
    step(mk(0, 0, 0,             1, 0, 0, 1, 32'h4,         NOP, 32'h0,         0), "w5");
    step(mk(0, 0, 0,             0, 1, B, 0, 32'h4,         B,   32'h4,         0), "w6");
    step(mk(0, 0, 0,             1, 0, 0, 1, 32'h8,         NOP, 32'h0,         0), "w7");
    @(negedge clk);
    imem_gnt = 0; rst = 1;
    #1;
    chk_reset("rst_wait");
    @(posedge clk);
    #1;
    chk_reset("rst_held_edge");
    @(negedge clk);
    rst = 0;
    step(mk(0, 0, 0, 1, 0, 0, 1, 32'h0, NOP, 32'h0, 0), "r0");
    step(mk(0, 0, 0, 0, 1, A, 0, 32'h0, A,   32'h0, 0), "r1");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
